// File: rtl/ebike_pkg.sv
// Shared types and widths for the e-bike motor-control slice.
//   ERR_W      : width of the signed error samples
//   DRV_W      : width of the unsigned drive magnitude
//   sched_st_t : PID update sequencer states
package ebike_pkg;

    localparam int unsigned ERR_W = 13;
    localparam int unsigned DRV_W = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        SLEW  = 3'd3,
        FAULT = 3'd4
    } sched_st_t;

endpackage

// File: rtl/drv_slew_lim.sv
// Combinational slew limiter: moves cur toward tgt by at most step.
// The result always lies between cur and tgt, so it never leaves 0..2^DRV_W-1.
//   cur    : present drive magnitude
//   tgt    : requested drive magnitude
//   step   : largest allowed change per update
//   next_c : limited drive magnitude (combinational)
module drv_slew_lim
    import ebike_pkg::*;
(
    input  logic [DRV_W-1:0] cur,
    input  logic [DRV_W-1:0] tgt,
    input  logic [DRV_W-1:0] step,
    output logic [DRV_W-1:0] next_c
);

    // One extra bit so cur + step cannot wrap before the compare.
    logic [DRV_W:0] up_sum;

    always_comb begin
        next_c = cur;
        up_sum = {1'b0, cur} + {1'b0, step};
        if (tgt > cur) begin
            next_c = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[DRV_W-1:0];
        end else if (tgt < cur) begin
            // cur - tgt > step implies cur > step, so cur - step cannot underflow.
            next_c = ((cur - tgt) <= step) ? tgt : (cur - step);
        end
    end

endmodule

// File: rtl/pid_update_sched.sv
// PID update sequencer for the motor loop: decimates error samples, starts the
// multi-cycle PID, waits for completion (with timeout) and slew-limits the drive.
//   clk, rst          : clock, synchronous active-high reset
//   smpl_vld/error_in : error sample strobe and value
//   not_pedaling      : rider idle; forces target to zero and clears integrator
//   fault_clr         : leaves the timeout fault state
//   pid_start/pid_err : PID launch strobe and latched error
//   pid_clr           : integrator clear level
//   pid_done/drv_raw  : PID completion strobe and raw output
//   drv_mag           : slew-limited motor drive
//   ovr               : qualifying sample dropped while busy
//   fault             : PID timeout flag
module pid_update_sched
    import ebike_pkg::*;
#(
    parameter int unsigned       DECIM     = 4,
    parameter logic [DRV_W-1:0]  SLEW_STEP = 12'd64,
    parameter int unsigned       TMO_CYC   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             smpl_vld,
    input  logic [ERR_W-1:0] error_in,
    input  logic             not_pedaling,
    input  logic             fault_clr,
    output logic             pid_start,
    output logic [ERR_W-1:0] pid_err,
    output logic             pid_clr,
    input  logic             pid_done,
    input  logic [DRV_W-1:0] drv_raw,
    output logic [DRV_W-1:0] drv_mag,
    output logic             ovr,
    output logic             fault
);

    localparam int unsigned DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned TCNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_START = START;
    localparam logic [2:0] ST_WAIT  = WAIT;
    localparam logic [2:0] ST_SLEW  = SLEW;
    localparam logic [2:0] ST_FAULT = FAULT;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [DCNT_W-1:0] dcnt;
    logic [DCNT_W-1:0] dcnt_nxt;
    logic [TCNT_W-1:0] tcnt;
    logic [DRV_W-1:0]  tgt;
    logic [DRV_W-1:0]  slew_c;
    logic              ovr_nxt;
    logic              dcnt_last;
    logic              tmo_hit;

    assign dcnt_last = (dcnt == DCNT_W'(DECIM - 1));
    assign tmo_hit   = (tcnt == TCNT_W'(TMO_CYC - 1));

    // Next state, decimation counter and overrun detection.
    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        ovr_nxt   = 1'b0;

        case (state)
            ST_IDLE:  if (smpl_vld && dcnt_last) state_nxt = ST_START;
            ST_START: state_nxt = ST_WAIT;
            ST_WAIT: begin
                // Completion beats a timeout landing in the same cycle.
                if (pid_done)     state_nxt = ST_SLEW;
                else if (tmo_hit) state_nxt = ST_FAULT;
            end
            ST_SLEW:  state_nxt = ST_IDLE;
            ST_FAULT: if (fault_clr) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase

        // Samples keep counting while busy; a qualifying one is dropped with ovr.
        if (state == ST_FAULT) begin
            if (fault_clr) dcnt_nxt = '0;
        end else if (smpl_vld) begin
            if (dcnt_last) begin
                dcnt_nxt = '0;
                ovr_nxt  = (state != ST_IDLE);
            end else begin
                dcnt_nxt = dcnt + DCNT_W'(1);
            end
        end
    end

    drv_slew_lim u_slew (
        .cur    (drv_mag),
        .tgt    (tgt),
        .step   (SLEW_STEP),
        .next_c (slew_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            dcnt      <= '0;
            tcnt      <= '0;
            tgt       <= '0;
            pid_start <= 1'b0;
            pid_err   <= '0;
            pid_clr   <= 1'b0;
            drv_mag   <= '0;
            ovr       <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_nxt;
            dcnt      <= dcnt_nxt;
            ovr       <= ovr_nxt;
            pid_start <= (state_nxt == ST_START);
            pid_clr   <= not_pedaling | (state_nxt == ST_FAULT);
            fault     <= (state_nxt == ST_FAULT);

            if ((state == ST_IDLE) && (state_nxt == ST_START)) pid_err <= error_in;

            if (state == ST_START)     tcnt <= '0;
            else if (state == ST_WAIT) tcnt <= tcnt + TCNT_W'(1);

            if ((state == ST_WAIT) && pid_done) tgt <= not_pedaling ? '0 : drv_raw;

            // Fault entry zeroes the drive at once, bypassing the slew limit.
            if (state_nxt == ST_FAULT)  drv_mag <= '0;
            else if (state == ST_SLEW)  drv_mag <= slew_c;
        end
    end

endmodule

// File: tb/tb_pid_update_sched.sv
// Scoreboard bench for pid_update_sched: stimulus pushes expected pid_err and
// drv_mag values; monitors pop and compare on pid_start and after pid_done.
module tb_pid_update_sched;
    import ebike_pkg::*;

    logic             clk;
    logic             rst;
    logic             smpl_vld;
    logic [ERR_W-1:0] error_in;
    logic             not_pedaling;
    logic             fault_clr;
    logic             pid_start;
    logic [ERR_W-1:0] pid_err;
    logic             pid_clr;
    logic             pid_done;
    logic [DRV_W-1:0] drv_raw;
    logic [DRV_W-1:0] drv_mag;
    logic             ovr;
    logic             fault;

    int n_cmp   = 0;
    int n_err   = 0;
    int ovr_cnt = 0;
    int ovr_base;

    logic [ERR_W-1:0] exp_err_q[$];
    logic [DRV_W-1:0] exp_drv_q[$];

    int               pid_lat  = 5;
    bit               pid_hang = 1'b0;
    logic [DRV_W-1:0] pid_val  = 12'd200;

    pid_update_sched dut (
        .clk          (clk),
        .rst          (rst),
        .smpl_vld     (smpl_vld),
        .error_in     (error_in),
        .not_pedaling (not_pedaling),
        .fault_clr    (fault_clr),
        .pid_start    (pid_start),
        .pid_err      (pid_err),
        .pid_clr      (pid_clr),
        .pid_done     (pid_done),
        .drv_raw      (drv_raw),
        .drv_mag      (drv_mag),
        .ovr          (ovr),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // PID datapath model: answers each pid_start after pid_lat cycles unless hung.
    initial begin
        pid_done = 1'b0;
        drv_raw  = '0;
        forever begin
            @(negedge clk);
            if (pid_start && !pid_hang) begin
                repeat (pid_lat) @(posedge clk);
                #1 pid_done = 1'b1; drv_raw = pid_val;
                @(posedge clk);
                #1 pid_done = 1'b0;
            end
        end
    end

    // Monitor: every pid_start must match the next expected latched error.
    initial begin
        forever begin
            @(negedge clk);
            if (pid_start) begin
                if (exp_err_q.size() == 0) begin
                    check("unexpected_pid_start", 32'(pid_err), 32'hFFFF_FFFF);
                end else begin
                    check("pid_err", 32'(pid_err), 32'(exp_err_q.pop_front()));
                end
            end
        end
    end

    // Monitor: drive magnitude two cycles after every pid_done.
    initial begin
        forever begin
            @(negedge clk);
            if (pid_done) begin
                repeat (2) @(negedge clk);
                if (exp_drv_q.size() == 0) begin
                    check("unexpected_pid_done", 32'(drv_mag), 32'hFFFF_FFFF);
                end else begin
                    check("drv_mag", 32'(drv_mag), 32'(exp_drv_q.pop_front()));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (ovr) ovr_cnt++;
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // One sample strobe followed by idle cycles; 10 clocks per call.
    task automatic send_sample(input logic [ERR_W-1:0] e);
        @(posedge clk);
        #1 smpl_vld = 1'b1; error_in = e;
        @(posedge clk);
        #1 smpl_vld = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    // Three filler samples then the qualifying fourth one.
    task automatic group4(input logic [ERR_W-1:0] e_fill, input logic [ERR_W-1:0] e_last);
        exp_err_q.push_back(e_last);
        repeat (3) send_sample(e_fill);
        send_sample(e_last);
    endtask

    initial begin
        rst          = 1'b1;
        smpl_vld     = 1'b0;
        error_in     = '0;
        not_pedaling = 1'b0;
        fault_clr    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pid_start", 32'(pid_start), 0);
        check("rst_pid_err",   32'(pid_err),   0);
        check("rst_pid_clr",   32'(pid_clr),   0);
        check("rst_drv_mag",   32'(drv_mag),   0);
        check("rst_ovr",       32'(ovr),       0);
        check("rst_fault",     32'(fault),     0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Pedaling ramp-up toward 200.
        exp_drv_q.push_back(12'd64);
        exp_drv_q.push_back(12'd128);
        exp_drv_q.push_back(12'd192);
        exp_drv_q.push_back(12'd200);
        repeat (4) group4(13'd500, 13'd500);
        check("ramp_final", 32'(drv_mag), 200);

        // Rider stops mid-WAIT: transaction completes, drive ramps to zero.
        exp_drv_q.push_back(12'd136);
        exp_drv_q.push_back(12'd72);
        exp_drv_q.push_back(12'd8);
        exp_drv_q.push_back(12'd0);
        exp_err_q.push_back(13'h1ED4);
        repeat (3) send_sample(13'h1ED4);
        fork
            begin
                repeat (3) @(posedge clk);
                #1 not_pedaling = 1'b1;
                @(negedge clk);
                check("pid_clr_lag", 32'(pid_clr), 0);
                @(negedge clk);
                check("pid_clr_set", 32'(pid_clr), 1);
            end
        join_none
        send_sample(13'h1ED4);
        repeat (3) group4(13'h1ED4, 13'h1ED4);
        check("pid_clr_hold", 32'(pid_clr), 1);

        // PID hang: timeout after 32 WAIT cycles forces drive to zero.
        not_pedaling = 1'b0;
        pid_val      = 12'd100;
        exp_drv_q.push_back(12'd64);
        group4(13'd20, 13'd21);
        pid_hang = 1'b1;
        group4(13'd30, 13'd31);
        repeat (25) @(negedge clk);
        check("pre_tmo_fault", 32'(fault),   0);
        check("pre_tmo_drv",   32'(drv_mag), 64);
        @(negedge clk);
        check("tmo_fault",   32'(fault),   1);
        check("tmo_drv",     32'(drv_mag), 0);
        check("tmo_pid_clr", 32'(pid_clr), 1);
        pid_hang = 1'b0;
        send_sample(13'd111);
        check("fault_sticky", 32'(fault), 1);
        @(posedge clk);
        #1 fault_clr = 1'b1;
        @(posedge clk);
        #1 fault_clr = 1'b0;
        @(negedge clk);
        check("fclr_fault",   32'(fault),   0);
        check("fclr_pid_clr", 32'(pid_clr), 0);
        exp_drv_q.push_back(12'd64);
        group4(13'd1, 13'd4);

        // Samples every clock with a slow PID: drops flagged, late done ignored.
        pid_lat  = 50;
        pid_val  = 12'd300;
        ovr_base = ovr_cnt;
        exp_err_q.push_back(13'd1003);
        exp_drv_q.push_back(12'd0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1 smpl_vld = 1'b1; error_in = ERR_W'(1000 + k);
        end
        @(posedge clk);
        #1 smpl_vld = 1'b0;
        repeat (60) @(posedge clk);
        check("ovr_pulses", 32'(ovr_cnt - ovr_base), 4);
        check("slow_fault", 32'(fault),   1);
        check("slow_drv",   32'(drv_mag), 0);
        @(posedge clk);
        #1 fault_clr = 1'b1;
        @(posedge clk);
        #1 fault_clr = 1'b0;
        @(negedge clk);
        check("slow_fclr", 32'(fault), 0);

        // pid_done coincides with the last WAIT cycle: completion wins.
        pid_lat = 32;
        pid_val = 12'd100;
        exp_drv_q.push_back(12'd64);
        group4(13'h1FFF, 13'h1FFE);
        repeat (25) @(negedge clk);
        check("tie_fault_a", 32'(fault),   0);
        check("tie_pid_clr", 32'(pid_clr), 0);
        @(negedge clk);
        check("tie_fault_b", 32'(fault), 0);
        repeat (5) @(posedge clk);

        // Reset while in WAIT; the late pid_done must be ignored afterwards.
        pid_lat = 20;
        exp_drv_q.push_back(12'd0);
        group4(13'h0ABC, 13'h1000);
        check("pre_rst_drv", 32'(drv_mag), 64);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("wrst_pid_start", 32'(pid_start), 0);
        check("wrst_pid_err",   32'(pid_err),   0);
        check("wrst_pid_clr",   32'(pid_clr),   0);
        check("wrst_drv_mag",   32'(drv_mag),   0);
        check("wrst_ovr",       32'(ovr),       0);
        check("wrst_fault",     32'(fault),     0);
        repeat (20) @(posedge clk);

        pid_lat = 5;
        exp_drv_q.push_back(12'd64);
        group4(13'd6, 13'd7);

        for (int i = 0; i < 100 && (exp_err_q.size() != 0 || exp_drv_q.size() != 0); i++)
            @(posedge clk);
        check("err_q_drained", 32'(exp_err_q.size()), 0);
        check("drv_q_drained", 32'(exp_drv_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
